// File: rtl/adc_ctrl.sv
// adc_ctrl: ADS1675 LVDS-mode sequencer and deserializer for the single DOUT line.
// Optional feature macro ADC_CTRL_SMP_CNT_EN adds the smp_cnt sample counter output.
module adc_ctrl #(
  parameter int CLK_DIV      = 12,
  parameter int PLL_WAIT_CYC = 17280,
  parameter int SETTLE_BITS  = 1330
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_pwdn,
  input  logic                         cfg_enable,
  input  logic [$clog2(CLK_DIV/3)-1:0] cfg_phase,
  input  logic [4:0]                   cfg_align,
  input  logic                         adc_dout,
  output logic                         adc_pwdn_n,
  output logic                         adc_clk,
  output logic                         adc_start,
  output logic                         smp_valid,
  output logic signed [23:0]           smp_data,
  output logic [2:0]                   state
`ifdef ADC_CTRL_SMP_CNT_EN
  ,
  output logic [31:0]                  smp_cnt
`endif
);

  localparam int HALF    = CLK_DIV / 2;
  localparam int BIT_DIV = CLK_DIV / 3;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int BPH_W   = $clog2(BIT_DIV);
  localparam int WAIT_W  = $clog2(PLL_WAIT_CYC + 2*CLK_DIV + 1);
  localparam int SET_W   = $clog2(SETTLE_BITS + 32 + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF   = DIV_W'(HALF);
  localparam logic [DIV_W-1:0]  DIV_PRE_FL = DIV_W'(HALF - 1);
  localparam logic [BPH_W-1:0]  BPH_LAST   = BPH_W'(BIT_DIV - 1);
  localparam logic [WAIT_W-1:0] PLL_LAST   = WAIT_W'(PLL_WAIT_CYC - 1);
  localparam logic [WAIT_W-1:0] DWELL_LAST = WAIT_W'(2*CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PLL_WAIT = 3'd1,
    ST_IDLE     = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_RUN      = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt, div_next;
  logic [BPH_W-1:0]   bit_ph, phase_r;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [SET_W-1:0]   tick_cnt, settle_tgt;
  logic               settle_go;
  logic               bit_tick, dwell_done, settle_done, settle_entry, smp_now;
  logic               dout_p0, dout_p1;
  logic [22:0]        shreg;
  logic [4:0]         bit_idx;

  assign div_next     = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  assign bit_tick     = (bit_ph == BPH_LAST);
  assign dwell_done   = (wait_cnt == DWELL_LAST);
  assign settle_done  = settle_go && bit_tick && (tick_cnt == settle_tgt - 1'b1);
  assign settle_entry = (state_q != ST_SETTLE) && (state_d == ST_SETTLE);
  assign smp_now      = (state_q == ST_RUN) && (state_d == ST_RUN) && (bit_ph == phase_r);
  assign state        = state_q;

  // adc_clk is registered so that it sits low during reset while div_cnt is 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_ph  <= '0;
      adc_clk <= 1'b0;
    end else begin
      div_cnt <= div_next;
      bit_ph  <= (div_next == '0 || bit_tick) ? '0 : bit_ph + 1'b1;
      adc_clk <= (div_next < DIV_HALF);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_OFF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:      if (!cfg_pwdn) state_d = ST_PLL_WAIT;
      ST_PLL_WAIT: if (wait_cnt == PLL_LAST) state_d = ST_IDLE;
      ST_IDLE:     if (cfg_enable && dwell_done) state_d = ST_SETTLE;
      ST_SETTLE:   if (!cfg_enable) state_d = ST_IDLE;
                   else if (settle_done) state_d = ST_RUN;
      ST_RUN:      if (!cfg_enable) state_d = ST_IDLE;
      default:     state_d = ST_OFF;
    endcase
    if (cfg_pwdn) state_d = ST_OFF;
  end

  // IDLE dwell only counts once adc_start is actually low, guaranteeing the START low pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_d != state_q) begin
      wait_cnt <= '0;
    end else if (state_q == ST_PLL_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else if (state_q == ST_IDLE && !adc_start && !dwell_done) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // settle ticks start after the first adc_clk rise that sees adc_start high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r    <= '0;
      settle_tgt <= '0;
      settle_go  <= 1'b0;
      tick_cnt   <= '0;
    end else if (settle_entry) begin
      phase_r    <= cfg_phase;
      settle_tgt <= SET_W'(SETTLE_BITS) + SET_W'(cfg_align);
      settle_go  <= 1'b0;
      tick_cnt   <= '0;
    end else if (state_q == ST_SETTLE) begin
      if (adc_start && div_cnt == '0) settle_go <= 1'b1;
      if (settle_go && bit_tick)      tick_cnt  <= tick_cnt + 1'b1;
    end
  end

  // adc_start moves only on the adc_clk falling edge, except for forced power-down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_pwdn_n <= 1'b0;
      adc_start  <= 1'b0;
    end else begin
      adc_pwdn_n <= (state_d != ST_OFF);
      if (state_d == ST_OFF)
        adc_start <= 1'b0;
      else if (div_cnt == DIV_PRE_FL)
        adc_start <= (state_d == ST_SETTLE) || (state_d == ST_RUN);
    end
  end

  // stage p0/p1: DOUT synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_p0 <= 1'b0;
      dout_p1 <= 1'b0;
    end else begin
      dout_p0 <= adc_dout;
      dout_p1 <= dout_p0;
    end
  end

  // stage p2: MSB-first shift and frame output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      bit_idx   <= '0;
      smp_data  <= '0;
      smp_valid <= 1'b0;
    end else begin
      smp_valid <= 1'b0;
      if (state_q != ST_RUN) begin
        bit_idx <= '0;
      end else if (smp_now) begin
        shreg <= {shreg[21:0], dout_p1};
        if (bit_idx == 5'd23) begin
          bit_idx   <= '0;
          smp_data  <= {shreg, dout_p1};
          smp_valid <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 1'b1;
        end
      end
    end
  end

`ifdef ADC_CTRL_SMP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            smp_cnt <= '0;
    else if (settle_entry) smp_cnt <= '0;
    else if (smp_valid)    smp_cnt <= smp_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_adc_ctrl.sv
// tb_adc_ctrl: randomized bench with an ADS1675 DOUT model and sample scoreboard for adc_ctrl.
module tb_adc_ctrl;
  localparam int CLK_DIV      = 12;
  localparam int PLL_WAIT_CYC = 300;
  localparam int SETTLE_BITS  = 15;
  localparam int BIT_DIV      = CLK_DIV / 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_pwdn = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [1:0]  cfg_phase = 2'd0;
  logic [4:0]  cfg_align = 5'd0;
  logic        adc_dout = 1'b0;
  logic        adc_pwdn_n, adc_clk, adc_start, smp_valid;
  logic [23:0] smp_data;
  logic [2:0]  state;
`ifdef ADC_CTRL_SMP_CNT_EN
  logic [31:0] smp_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  adc_ctrl #(
    .CLK_DIV(CLK_DIV), .PLL_WAIT_CYC(PLL_WAIT_CYC), .SETTLE_BITS(SETTLE_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_pwdn(cfg_pwdn), .cfg_enable(cfg_enable),
    .cfg_phase(cfg_phase), .cfg_align(cfg_align), .adc_dout(adc_dout),
    .adc_pwdn_n(adc_pwdn_n), .adc_clk(adc_clk), .adc_start(adc_start),
    .smp_valid(smp_valid), .smp_data(smp_data), .state(state)
`ifdef ADC_CTRL_SMP_CNT_EN
    , .smp_cnt(smp_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ADC model: settles SETTLE_BITS+align bits after the first adc_clk rise with START high,
  // then streams consecutive 24-bit words from a random base, MSB first.
  int          tb_phase = 2;
  int          tb_align = 0;
  bit          bfm_on = 1'b0;
  int          bfm_t, bfm_b, bfm_fr, bfm_pos;
  logic        bfm_clk_q = 1'b0;
  logic [23:0] bfm_base, bfm_w, bfm_prev;
  logic [23:0] exp_q[$];

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      bfm_on   = 1'b0;
      adc_dout = 1'b0;
    end else begin
      if (bfm_on) bfm_t++;
      if (adc_clk && !bfm_clk_q) begin
        if (!adc_start) bfm_on = 1'b0;
        else if (!bfm_on) begin
          bfm_on   = 1'b1;
          bfm_t    = 0;
          bfm_base = 24'($urandom);
        end
      end
      adc_dout = 1'b0;
      if (bfm_on) begin
        bfm_b = bfm_t / BIT_DIV - (SETTLE_BITS + tb_align);
        if (bfm_b >= 0) begin
          bfm_fr   = bfm_b / 24;
          bfm_pos  = bfm_b % 24;
          bfm_w    = bfm_base + 24'(bfm_fr);
          bfm_prev = bfm_w - 24'd1;
          adc_dout = bfm_w[23 - bfm_pos];
          // early sample phases see the previous bit through the 2-flop synchronizer
          if (bfm_pos == 0 && (bfm_t % BIT_DIV) == 0)
            exp_q.push_back((tb_phase >= 2) ? bfm_w
                            : {((bfm_fr == 0) ? 1'b0 : bfm_prev[0]), bfm_w[23:1]});
        end
      end
    end
    bfm_clk_q = adc_clk;
  end

  // monitor: START edge timing, sample data, frame spacing and first-sample latency
  int   n_valid = 0;
  int   n_seg = 0;
  int   last_v = 0;
  int   start_rise_cyc = 0;
  int   start_fall_cyc = 0;
  bit   have_fall = 1'b0;
  bit   seg_first = 1'b1;
  logic start_q = 1'b0;
  logic aclk_q = 1'b0;
  logic [2:0] st_q = 3'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_fall = 1'b0;
      n_seg     = 0;
    end else begin
      if (state == 3'd3 && st_q != 3'd3) n_seg = 0;
      if (adc_start && !start_q) begin
        if (!cfg_pwdn) chk("start_rise_on_clk_fall", {30'd0, aclk_q, adc_clk}, 32'd2);
        if (have_fall) chk("start_low_min", 32'((cyc - start_fall_cyc) >= 2*CLK_DIV), 32'd1);
        start_rise_cyc = cyc;
      end
      if (!adc_start && start_q) begin
        if (!cfg_pwdn) chk("start_fall_on_clk_fall", {30'd0, aclk_q, adc_clk}, 32'd2);
        start_fall_cyc = cyc;
        have_fall      = 1'b1;
      end
      if (smp_valid) begin
        n_valid++;
        chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("smp_data", {8'd0, smp_data}, {8'd0, exp_q.pop_front()});
        if (seg_first)
          chk("first_latency", cyc - start_rise_cyc,
              6 + BIT_DIV*(SETTLE_BITS + tb_align + 23) + tb_phase + 1);
        else
          chk("frame_period", cyc - last_v, 24*BIT_DIV);
`ifdef ADC_CTRL_SMP_CNT_EN
        chk("smp_cnt", smp_cnt, n_seg);
`endif
        n_seg++;
        seg_first = 1'b0;
        last_v    = cyc;
      end
    end
    start_q = adc_start;
    aclk_q  = adc_clk;
    st_q    = state;
  end

  task automatic wait_valids(input int n);
    int tgt;
    int budget;
    tgt    = n_valid + n;
    budget = 0;
    while (n_valid < tgt && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    chk("valid_timeout", 32'(n_valid >= tgt), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pwdn_n"}, {31'd0, adc_pwdn_n}, 32'd0);
    chk({tag, "_start"},  {31'd0, adc_start},  32'd0);
    chk({tag, "_adc_clk"}, {31'd0, adc_clk},   32'd0);
    chk({tag, "_valid"},  {31'd0, smp_valid},  32'd0);
    chk({tag, "_data"},   {8'd0, smp_data},    32'd0);
    chk({tag, "_state"},  {29'd0, state},      32'd0);
  endtask

  task automatic set_cfg(input int ph);
    tb_phase  = ph;
    tb_align  = $urandom_range(0, 31);
    cfg_phase = 2'(tb_phase);
    cfg_align = 5'(tb_align);
  endtask

  initial begin
    int t_rel;
    int n0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");

    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("off_hold_state", {29'd0, state}, 32'd0);
    chk("off_hold_pwdn_n", {31'd0, adc_pwdn_n}, 32'd0);

    // power-up with enable held
    set_cfg(2 + $urandom_range(0, 1));
    cfg_enable = 1'b1;
    cfg_pwdn   = 1'b0;
    t_rel      = cyc;
    @(negedge clk);
    chk("pwdn_n_rise", {31'd0, adc_pwdn_n}, 32'd1);
    chk("state_pll_wait", {29'd0, state}, 32'd1);
    wait_valids(6);
    chk("start_not_early", 32'((start_rise_cyc - t_rel) >= PLL_WAIT_CYC + 2*CLK_DIV), 32'd1);
    chk("start_not_late", 32'((start_rise_cyc - t_rel) <= PLL_WAIT_CYC + 3*CLK_DIV + 1), 32'd1);

    // enable drop mid-frame, then re-enable at every sample phase
    for (int p = 0; p < 4; p++) begin
      wait_valids(1);
      repeat (10*BIT_DIV) @(negedge clk);
      cfg_enable = 1'b0;
      n0 = n_valid;
      @(negedge clk);
      chk("drop_state_idle", {29'd0, state}, 32'd2);
      repeat (CLK_DIV + 1) @(negedge clk);
      chk("drop_start_low", {31'd0, adc_start}, 32'd0);
      repeat (150) @(negedge clk);
      chk("drop_no_valid", n_valid - n0, 32'd0);
      exp_q.delete();
      seg_first = 1'b1;
      set_cfg(p);
      cfg_enable = 1'b1;
      wait_valids(4);
    end

    // forced power-down in RUN, then a full PLL wait on release
    wait_valids(1);
    repeat (20) @(negedge clk);
    cfg_pwdn = 1'b1;
    @(negedge clk);
    chk("pwdn_pwdn_n", {31'd0, adc_pwdn_n}, 32'd0);
    chk("pwdn_start", {31'd0, adc_start}, 32'd0);
    chk("pwdn_state", {29'd0, state}, 32'd0);
    repeat (30) @(negedge clk);
    exp_q.delete();
    seg_first = 1'b1;
    set_cfg(2 + $urandom_range(0, 1));
    cfg_pwdn = 1'b0;
    @(negedge clk);
    chk("repwr_state", {29'd0, state}, 32'd1);
    chk("repwr_pwdn_n", {31'd0, adc_pwdn_n}, 32'd1);
    repeat (PLL_WAIT_CYC - 1) @(negedge clk);
    chk("pll_wait_full", {29'd0, state}, 32'd1);
    @(negedge clk);
    chk("pll_wait_done", {29'd0, state}, 32'd2);
    wait_valids(3);

    // asynchronous reset between clock edges, mid-frame
    repeat (30) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    chk("async_rst_valid_hold", {31'd0, smp_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
